// File: rtl/median_pkg.sv
// Shared types and constants for the 5x5 median path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package median_pkg;

    localparam int KERNEL_SIZE   = 5;
    localparam int KERNEL_RADIUS = KERNEL_SIZE / 2;
    localparam int DIM_WIDTH     = 13;

    typedef logic [DIM_WIDTH-1:0] dim_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } seq_state_t;

endpackage

// File: rtl/kernel_window_sequencer_frame_position_counter.sv
// Column/row tracker for the next pixel to enter the kernel buffer.
// Latency: position registered; eol/eof decode is combinational on the current position.
// Backpressure: none; advances only on en, holds otherwise.
//
// Ports:
//   i_clk, i_aresetn : clock, async active-low reset
//   load             : restart at the SOF pixel; next position is (0,1)
//   en               : one pixel accepted at the current position
//   clear            : return to (0,0) (aborted frame)
//   w_q, h_q         : latched frame dimensions
//   col, row         : position of the next pixel to arrive
//   eol, eof         : current position is the last of a line / of the frame
module frame_position_counter #(
    parameter int DIM_WIDTH = 13
) (
    input  logic                 i_clk,
    input  logic                 i_aresetn,
    input  logic                 load,
    input  logic                 en,
    input  logic                 clear,
    input  logic [DIM_WIDTH-1:0] w_q,
    input  logic [DIM_WIDTH-1:0] h_q,
    output logic [DIM_WIDTH-1:0] col,
    output logic [DIM_WIDTH-1:0] row,
    output logic                 eol,
    output logic                 eof
);

    localparam logic [DIM_WIDTH-1:0] ONE = DIM_WIDTH'(1);

    // Dimensions are at least KERNEL_SIZE whenever the frame is active,
    // so the minus-one never wraps in any cycle where these are used.
    assign eol = (col == (w_q - ONE));
    assign eof = eol && (row == (h_q - ONE));

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (load) begin
            // The SOF pixel itself occupies (0,0).
            col <= ONE;
            row <= '0;
        end else if (en) begin
            if (eof) begin
                col <= '0;
                row <= '0;
            end else if (eol) begin
                col <= '0;
                row <= row + ONE;
            end else begin
                col <= col + ONE;
            end
        end
    end

endmodule

// File: rtl/kernel_window_sequencer.sv
// Frame-position controller: flags cycles where the kernel buffer holds a full in-frame window.
// Latency: window flags/centre zero-cycle; frame_done/frame_error/busy one cycle registered.
// Backpressure: none; follows i_data_valid, idle cycles hold all position state.
//
// Ports:
//   i_clk, i_aresetn            : clock, async active-low reset
//   IMAGE_WIDTH, IMAGE_HEIGHT   : frame dimensions, sampled on the SOF pixel
//   i_data_valid                : kernel buffer shifted in a pixel this cycle
//   i_start_of_frame            : that pixel is the first of a frame
//   o_window_valid/sof/eol/eof  : window present this cycle and its frame markers
//   o_center_col, o_center_row  : window centre in output coordinates (0 when no window)
//   o_frame_done, o_frame_error : single-cycle pulses after the triggering pixel
//   o_busy                      : a frame is in progress
module kernel_window_sequencer #(
    parameter int KERNEL_SIZE = 5,
    parameter int DIM_WIDTH   = 13
) (
    input  logic                 i_clk,
    input  logic                 i_aresetn,
    input  logic [DIM_WIDTH-1:0] IMAGE_WIDTH,
    input  logic [DIM_WIDTH-1:0] IMAGE_HEIGHT,
    input  logic                 i_data_valid,
    input  logic                 i_start_of_frame,
    output logic                 o_window_valid,
    output logic                 o_window_sof,
    output logic                 o_window_eol,
    output logic                 o_window_eof,
    output logic [DIM_WIDTH-1:0] o_center_col,
    output logic [DIM_WIDTH-1:0] o_center_row,
    output logic                 o_frame_done,
    output logic                 o_frame_error,
    output logic                 o_busy
);

    import median_pkg::*;

    localparam logic [DIM_WIDTH-1:0] K_SIZE = DIM_WIDTH'(KERNEL_SIZE);
    localparam logic [DIM_WIDTH-1:0] K_LAST = DIM_WIDTH'(KERNEL_SIZE - 1);
    localparam logic [DIM_WIDTH-1:0] K_RAD  = DIM_WIDTH'(KERNEL_SIZE / 2);

    seq_state_t state, state_nxt;

    logic [DIM_WIDTH-1:0] w_q, h_q;
    logic [DIM_WIDTH-1:0] col, row;
    logic                 pos_eol, pos_eof;

    logic sof_px;      // SOF pixel, accepted in any state
    logic dims_ok;     // sampled dimensions can hold at least one window
    logic adv;         // ordinary pixel inside an active frame
    logic done_nxt;
    logic error_nxt;
    logic frame_done_q;
    logic frame_error_q;

    assign sof_px  = i_data_valid && i_start_of_frame;
    assign dims_ok = (IMAGE_WIDTH >= K_SIZE) && (IMAGE_HEIGHT >= K_SIZE);
    assign adv     = i_data_valid && !i_start_of_frame && (state == ACTIVE);

    // Dimensions are latched on every SOF; an undersized frame never goes
    // ACTIVE, so stale values are never decoded against.
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            w_q <= '0;
            h_q <= '0;
        end else if (sof_px) begin
            w_q <= IMAGE_WIDTH;
            h_q <= IMAGE_HEIGHT;
        end
    end

    frame_position_counter #(
        .DIM_WIDTH (DIM_WIDTH)
    ) u_pos (
        .i_clk     (i_clk),
        .i_aresetn (i_aresetn),
        .load      (sof_px && dims_ok),
        .en        (adv),
        .clear     (sof_px && !dims_ok),
        .w_q       (w_q),
        .h_q       (h_q),
        .col       (col),
        .row       (row),
        .eol       (pos_eol),
        .eof       (pos_eof)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: SOF always restarts (or aborts on bad dimensions),
    // the last pixel of the frame returns to IDLE.
    always_comb begin
        state_nxt = state;
        if (sof_px) begin
            state_nxt = dims_ok ? ACTIVE : IDLE;
        end else if (adv && pos_eof) begin
            state_nxt = IDLE;
        end
    end

    // Output logic: zero-latency window decode aligned with the kernel
    // buffer, plus next values for the registered pulses.
    always_comb begin
        o_window_valid = 1'b0;
        o_window_sof   = 1'b0;
        o_window_eol   = 1'b0;
        o_window_eof   = 1'b0;
        o_center_col   = '0;
        o_center_row   = '0;
        done_nxt       = 1'b0;
        error_nxt      = 1'b0;

        if (adv && (row >= K_LAST) && (col >= K_LAST)) begin
            o_window_valid = 1'b1;
            o_window_sof   = (row == K_LAST) && (col == K_LAST);
            o_window_eol   = pos_eol;
            o_window_eof   = pos_eof;
            o_center_col   = col - K_RAD;
            o_center_row   = row - K_RAD;
        end

        done_nxt  = adv && pos_eof;
        // A SOF mid-frame and a SOF with unusable dimensions are both
        // reported through the same single pulse.
        error_nxt = sof_px && ((state == ACTIVE) || !dims_ok);
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            frame_done_q  <= done_nxt;
            frame_error_q <= error_nxt;
        end
    end

    assign o_frame_done  = frame_done_q;
    assign o_frame_error = frame_error_q;
    assign o_busy        = (state == ACTIVE);

endmodule

// File: doc/kernel_window_sequencer.md
# kernel_window_sequencer

Frame-position controller for the 5x5 median path. Sits beside `AXIS_pixel_receiver` and consumes that receiver's registered `o_data_valid` and `o_start_of_frame`. It tracks the column and row of every pixel shifted into the kernel buffer. It tells the median stage which cycles hold a complete, in-frame 5x5 window, and where that window's centre is; border windows are discarded, so the output image is (W-4)x(H-4).

## Interface
- `KERNEL_SIZE`, 5, kernel edge length; radius R = KERNEL_SIZE/2.
- `DIM_WIDTH`, 13, width of dimension and position values.

- `i_clk` in 1: clock.
- `i_aresetn` in 1: asynchronous, active-low reset.
- `IMAGE_WIDTH` in DIM_WIDTH: pixels per line W; sampled at SOF.
- `IMAGE_HEIGHT` in DIM_WIDTH: lines per frame H; sampled at SOF.
- `i_data_valid` in 1: receiver `o_data_valid`; the kernel buffer was updated this cycle.
- `i_start_of_frame` in 1: receiver `o_start_of_frame`; meaningful only with `i_data_valid`.
- `o_window_valid` out 1: the kernel buffer holds a full in-frame window this cycle.
- `o_window_sof` out 1: first valid window of the frame.
- `o_window_eol` out 1: last valid window of a line.
- `o_window_eof` out 1: last valid window of the frame.
- `o_center_col` out DIM_WIDTH: window centre column (c-R).
- `o_center_row` out DIM_WIDTH: window centre row (r-R).
- `o_frame_done` out 1: one-cycle pulse after the last pixel is accepted.
- `o_frame_error` out 1: one-cycle pulse on a protocol or dimension error.
- `o_busy` out 1: high while in ACTIVE.

## Operation
- **States:** IDLE, ACTIVE.
- **Counters:** registered `col`, `row` and latched `w_q`, `h_q`, all DIM_WIDTH bits wide. They give the position (r,c) of the next pixel to arrive.
- **Accepted pixel:** `i_data_valid`=1.
  - In IDLE, a pixel is accepted only when `i_start_of_frame`=1.
  - Pixels in IDLE without SOF are ignored; no output is asserted.
- **SOF in any state:**
  - Latch `w_q`=IMAGE_WIDTH and `h_q`=IMAGE_HEIGHT.
  - The SOF pixel is (0,0); next `col`=1, `row`=0; state becomes ACTIVE.
- **SOF while ACTIVE:** `o_frame_error` pulses and the frame restarts as above (the new SOF pixel is (0,0)).
- **SOF with W<KERNEL_SIZE or H<KERNEL_SIZE:** `o_frame_error` pulses and the state stays or returns to IDLE.
- **Accepted pixel in ACTIVE (no SOF):**
  - `col`++.
  - At c=w_q-1: `col`=0, `row`++.
  - At (h_q-1, w_q-1): `o_frame_done` pulses next cycle, counters clear, state goes to IDLE.
- **Window decode** (combinational on current-pixel position and `i_data_valid`, zero latency so it aligns with the kernel buffer contents):
  - `o_window_valid` = accepted && r>=KERNEL_SIZE-1 && c>=KERNEL_SIZE-1.
  - `o_window_sof` = valid && r==KERNEL_SIZE-1 && c==KERNEL_SIZE-1.
  - `o_window_eol` = valid && c==w_q-1.
  - `o_window_eof` = eol && r==h_q-1.
  - `o_center_col` = c-R and `o_center_row` = r-R when valid, 0 otherwise.
- **Arithmetic:** unsigned DIM_WIDTH-bit; comparisons against w_q-1 and h_q-1 with no wrap. W or H of 0 is caught by the minimum-size check.
- **Reset mid-frame:** all state is lost; the next accepted pixel must carry SOF.

## Timing
- **Reset values:** all outputs 0; state IDLE; counters 0.
- **Window flags and centre outputs:** same cycle as `i_data_valid`, no latency.
- **`o_frame_done` and `o_frame_error`:** registered, 1 cycle after the triggering pixel, exactly one cycle wide.
- **`o_busy`:** registered; rises the cycle after SOF and falls together with `o_frame_done`.
- **Idle cycles:** `i_data_valid`=0 cycles between pixels hold all counters.
- **Back-to-back frames:** a SOF on the cycle after the last pixel is accepted normally, with no error.

## Structure
- **Package `median_pkg`:**
  - constants KERNEL_SIZE, KERNEL_RADIUS, DIM_WIDTH;
  - typedef `dim_t` = logic [DIM_WIDTH-1:0];
  - enum `seq_state_t` {IDLE, ACTIVE}.
- **Sub-module `frame_position_counter`:** col/row counter with enable, load-to-(0,0)+1, and end-of-line/end-of-frame outputs. The window decode and FSM stay in the top module.

## Test plan
- **Nominal frame:** W=10, H=10, one pixel per cycle from SOF -> 36 `o_window_valid` pulses.
  - The first has `o_window_sof` with centre (2,2).
  - Each line ends with `o_window_eol` at centre col 7.
  - The last has `o_window_eof` at centre (7,7).
  - `o_frame_done` follows 1 cycle later.
- **Gapped input:** same frame with `i_data_valid` toggled at random -> identical sequence of centres; counters hold across gaps.
- **Early SOF:** SOF at pixel 57 of a 10x10 frame -> `o_frame_error` 1 cycle later; the restart window sequence begins at centre (2,2) 44 accepted pixels after the new SOF.
- **Undersized frame:** W=4, H=10 SOF -> `o_frame_error`, state stays IDLE, no `o_window_valid`.
- **Idle input:** data without SOF after reset -> all outputs stay 0.
- **Async reset:** reset asserted at pixel 30 -> all outputs 0 immediately; a following 5x5 frame yields a single window at (2,2) carrying sof, eol and eof together.
